spu_sequencer: RTL and testbench
================================

SPU_SEQUENCER -- requirements
Module: spu_sequencer

Interface
REQ-001 SHALL have parameter EXEC_LAT, default 1, meaning cycles spent in EXEC before result capture (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream nibble valid.
REQ-005 SHALL have port in_data  input  4  opcode or operand nibble.
REQ-006 SHALL have port in_ready  output  1  sequencer accepts a nibble this cycle.
REQ-007 SHALL have port abort  input  1  synchronous cancel of an operation being loaded.
REQ-008 SHALL have port op_code  output  4  registered opcode driving the op-unit select mux.
REQ-009 SHALL have ports op_A, op_B, op_C, op_D  output  4 each  registered operands to the op units.
REQ-010 SHALL have ports res_M, res_N  input  4 each  combinational results from the selected op unit.
REQ-011 SHALL have ports M, N  output  4 each  registered result; also fed back to op units as current_M/current_N.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done_count  output  8  completed-operation counter.

Function
REQ-016 SHALL implement states IDLE, LD_A, LD_B, LD_C, LD_D, EXEC, DONE.
REQ-017 SHALL define a beat as in_valid && in_ready at a rising edge; in_ready = 1 exactly in IDLE and LD_A..LD_D.
REQ-018 IDLE: on a beat, capture in_data into op_code; opcode 0x0 (NOP) -> DONE, any other -> LD_A.
REQ-019 LD_A..LD_D: on a beat, capture in_data into op_A..op_D respectively and advance LD_A->LD_B->LD_C->LD_D->EXEC; no beat -> hold state.
REQ-020 SHALL hold op_code and op_A..op_D stable from capture until the next opcode beat in IDLE.
REQ-021 EXEC: a 4-bit counter loaded with EXEC_LAT-1 on entry decrements each cycle; on the cycle it reads 0, M<=res_M, N<=res_N and state -> DONE.
REQ-022 Latency from the LD_D beat to out_valid high SHALL be exactly EXEC_LAT+1 cycles.
REQ-023 NOP path: M and N SHALL be unchanged, op_A..op_D unchanged, out_valid high the cycle after the opcode beat.
REQ-024 DONE: out_valid = 1; hold DONE, M and N until out_ready = 1; on out_valid && out_ready -> IDLE and increment done_count.
REQ-025 out_valid SHALL be 0 in every state except DONE.
REQ-026 done_count SHALL wrap 0xFF -> 0x00 without any flag.
REQ-027 abort = 1 in LD_A..LD_D SHALL return to IDLE next cycle and discard the pending operation; M, N and done_count unchanged; abort takes priority over a simultaneous beat.
REQ-028 abort in IDLE, EXEC or DONE SHALL be ignored; an abort coinciding with an IDLE opcode beat SHALL NOT block the beat.
REQ-029 in_valid/in_data SHALL be ignored while in_ready = 0.
REQ-030 EXEC_LAT outside 1..15 SHALL be treated as 1.

Reset
REQ-031 rst = 1 SHALL immediately force state IDLE and op_code, op_A..op_D, M, N, done_count to 0, out_valid 0, busy 0, independent of clk.
REQ-032 rst asserted mid-load, mid-EXEC or in DONE SHALL discard the operation; after release the first beat is treated as an opcode.

Verification
REQ-033 EXEC_LAT=1; beats 0x3,0x1,0x2,0x4,0x5 with res_M=0xA,res_N=0xB, out_ready=1 -> out_valid 2 cycles after 0x5 beat, M=0xA,N=0xB, done_count=1.
REQ-034 Beat 0x0 with M=0x7,N=0x9 prior -> out_valid next cycle, M=0x7,N=0x9, op_A..op_D unchanged, no LD states visited.
REQ-035 EXEC_LAT=4, out_ready=0 for 5 cycles after DONE -> out_valid and M/N held 5 cycles, in_ready=0, extra in_valid pulses ignored, then IDLE.
REQ-036 Opcode 0x2, beats A,B, then abort with simultaneous in_valid -> IDLE next cycle, next beat 0x0 taken as NOP, M/N unchanged.
REQ-037 256 NOPs with out_ready=1 -> done_count returns to 0x00.
REQ-038 rst pulse between clock edges during EXEC -> all outputs 0 immediately, state IDLE; next sequence completes normally.

Source files
------------

// File: rtl/spu_sequencer.sv
// Nibble-serial operation sequencer: loads an opcode and four operands, waits
// EXEC_LAT cycles for the selected op unit, then holds the result until taken.
module spu_sequencer #(
  parameter int EXEC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  input  logic       abort,
  output logic [3:0] op_code,
  output logic [3:0] op_A,
  output logic [3:0] op_B,
  output logic [3:0] op_C,
  output logic [3:0] op_D,
  input  logic [3:0] res_M,
  input  logic [3:0] res_N,
  output logic [3:0] M,
  output logic [3:0] N,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic [7:0] done_count
);

  // Out-of-range latencies collapse to a single EXEC cycle.
  localparam logic [3:0] LAT_M1 = (EXEC_LAT >= 1 && EXEC_LAT <= 15) ? 4'(EXEC_LAT - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE, LD_A, LD_B, LD_C, LD_D, EXEC, DONE
  } state_t;

  state_t     state_reg;
  logic [3:0] cnt_reg;

  assign in_ready  = (state_reg == IDLE) || (state_reg == LD_A) || (state_reg == LD_B) ||
                     (state_reg == LD_C) || (state_reg == LD_D);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      op_code    <= 4'd0;
      op_A       <= 4'd0;
      op_B       <= 4'd0;
      op_C       <= 4'd0;
      op_D       <= 4'd0;
      M          <= 4'd0;
      N          <= 4'd0;
      done_count <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // abort is deliberately not looked at here: it never blocks an opcode.
          if (in_valid) begin
            op_code   <= in_data;
            state_reg <= (in_data == 4'h0) ? DONE : LD_A;
          end
        end
        LD_A: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (in_valid) begin
            op_A      <= in_data;
            state_reg <= LD_B;
          end
        end
        LD_B: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (in_valid) begin
            op_B      <= in_data;
            state_reg <= LD_C;
          end
        end
        LD_C: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (in_valid) begin
            op_C      <= in_data;
            state_reg <= LD_D;
          end
        end
        LD_D: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (in_valid) begin
            op_D      <= in_data;
            cnt_reg   <= LAT_M1;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_reg == 4'd0) begin
            M         <= res_M;
            N         <= res_N;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            done_count <= done_count + 8'd1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_sequencer.sv
// Bench for spu_sequencer: three instances (EXEC_LAT 1, 4 and out-of-range 0)
// driven from a vector table, with a result scoreboard and corner sequences.
module tb_spu_sequencer;

  localparam int ND = 3;

  typedef struct {
    logic [3:0] op, a, b, c, d;
    logic [3:0] rm, rn;
    int         hold;
    logic [3:0] em, en;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid [ND];
  logic [3:0] in_data [ND];
  logic       abort [ND];
  logic [3:0] res_m [ND];
  logic [3:0] res_n [ND];
  logic       out_ready [ND];
  logic       in_ready [ND];
  logic [3:0] op_code [ND];
  logic [3:0] op_a [ND];
  logic [3:0] op_b [ND];
  logic [3:0] op_c [ND];
  logic [3:0] op_d [ND];
  logic [3:0] m [ND];
  logic [3:0] n [ND];
  logic       out_valid [ND];
  logic       busy [ND];
  logic [7:0] done_count [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      spu_sequencer #(.EXEC_LAT(gi == 0 ? 1 : (gi == 1 ? 4 : 0))) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[gi]), .in_data(in_data[gi]), .in_ready(in_ready[gi]),
        .abort(abort[gi]),
        .op_code(op_code[gi]), .op_A(op_a[gi]), .op_B(op_b[gi]), .op_C(op_c[gi]), .op_D(op_d[gi]),
        .res_M(res_m[gi]), .res_N(res_n[gi]), .M(m[gi]), .N(n[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
        .busy(busy[gi]), .done_count(done_count[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb [$];
  logic [3:0] mdl_op [ND][5];
  logic [3:0] mdl_m [ND];
  logic [3:0] mdl_n [ND];
  logic [7:0] mdl_cnt [ND];
  vec_t       vecs [6];

  function automatic int eff_lat(int d);
    int raw;
    raw = (d == 0) ? 1 : ((d == 1) ? 4 : 0);
    return (raw < 1 || raw > 15) ? 1 : raw;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
    end
  endtask

  task automatic chk_ops(string nm, int d);
    chk({nm, "_opcode"}, d, op_code[d], mdl_op[d][0]);
    chk({nm, "_opA"}, d, op_a[d], mdl_op[d][1]);
    chk({nm, "_opB"}, d, op_b[d], mdl_op[d][2]);
    chk({nm, "_opC"}, d, op_c[d], mdl_op[d][3]);
    chk({nm, "_opD"}, d, op_d[d], mdl_op[d][4]);
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 5; k++) mdl_op[d][k] = 4'h0;
      mdl_m[d] = 4'h0;
      mdl_n[d] = 4'h0;
      mdl_cnt[d] = 8'h00;
    end
  endtask

  task automatic run_vec(int d, vec_t v, logic ab);
    logic [3:0] opnd [4];
    logic [7:0] exp;
    int         cnt;
    opnd[0] = v.a; opnd[1] = v.b; opnd[2] = v.c; opnd[3] = v.d;
    sb.push_back({v.em, v.en});
    chk("idle_ready", d, in_ready[d], 1'b1);
    in_valid[d] = 1'b1; in_data[d] = v.op; abort[d] = ab;
    res_m[d] = v.rm; res_n[d] = v.rn;
    tick();
    abort[d] = 1'b0;
    mdl_op[d][0] = v.op;
    if (v.op != 4'h0) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 2) begin
          in_valid[d] = 1'b0;
          tick();
          chk("ld_gap_ready", d, in_ready[d], 1'b1);
          chk("ld_gap_busy", d, busy[d], 1'b1);
        end
        in_valid[d] = 1'b1; in_data[d] = opnd[k];
        tick();
        mdl_op[d][k+1] = opnd[k];
      end
    end
    // Junk beats while not ready must be ignored.
    in_valid[d] = 1'b1; in_data[d] = 4'hE;
    cnt = 0;
    while (!out_valid[d] && cnt < 40) begin
      chk("exec_ready", d, in_ready[d], 1'b0);
      tick();
      cnt++;
    end
    chk("latency", d, cnt, (v.op == 4'h0) ? 0 : eff_lat(d));
    chk_ops("done", d);
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_valid", d, out_valid[d], 1'b1);
      chk("hold_ready", d, in_ready[d], 1'b0);
      chk("hold_mn", d, {m[d], n[d]}, sb[0]);
      tick();
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    exp = sb.pop_front();
    chk("res_valid", d, out_valid[d], 1'b1);
    chk("res_mn", d, {m[d], n[d]}, exp);
    tick();
    out_ready[d] = 1'b0;
    mdl_m[d] = exp[7:4]; mdl_n[d] = exp[3:0];
    mdl_cnt[d] = mdl_cnt[d] + 8'd1;
    chk("done_count", d, done_count[d], mdl_cnt[d]);
    chk("post_valid", d, out_valid[d], 1'b0);
    chk("post_busy", d, busy[d], 1'b0);
    $display("txn dut%0d op=%0h M=%0h N=%0h done_count=%0d", d, v.op, m[d], n[d], done_count[d]);
  endtask

  task automatic abort_seq(int d);
    vec_t nop;
    in_valid[d] = 1'b1; in_data[d] = 4'h2; tick(); mdl_op[d][0] = 4'h2;
    in_data[d] = 4'h3; tick(); mdl_op[d][1] = 4'h3;
    in_data[d] = 4'h4; tick(); mdl_op[d][2] = 4'h4;
    abort[d] = 1'b1; in_data[d] = 4'h9;
    tick();
    abort[d] = 1'b0; in_valid[d] = 1'b0;
    chk("abort_busy", d, busy[d], 1'b0);
    chk("abort_ready", d, in_ready[d], 1'b1);
    chk("abort_mn", d, {m[d], n[d]}, {mdl_m[d], mdl_n[d]});
    chk("abort_count", d, done_count[d], mdl_cnt[d]);
    chk_ops("abort", d);
    // The NOP opcode arrives with abort still high; it must still be taken.
    nop = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 1, mdl_m[d], mdl_n[d]};
    run_vec(d, nop, 1'b1);
  endtask

  task automatic nop_burst(int d);
    logic [7:0] start;
    start = done_count[d];
    out_ready[d] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid[d] = 1'b1; in_data[d] = 4'h0;
      tick();
      in_valid[d] = 1'b0;
      chk("burst_valid", d, out_valid[d], 1'b1);
      tick();
    end
    out_ready[d] = 1'b0;
    chk("burst_wrap", d, done_count[d], start);
    chk("burst_mn", d, {m[d], n[d]}, {mdl_m[d], mdl_n[d]});
    $display("txn dut%0d 256 nops done_count=%0d", d, done_count[d]);
  endtask

  task automatic reset_mid_exec(int d);
    logic [3:0] ld [5];
    ld[0] = 4'h6; ld[1] = 4'h1; ld[2] = 4'h2; ld[3] = 4'h3; ld[4] = 4'h4;
    res_m[d] = 4'h8; res_n[d] = 4'h8;
    for (int k = 0; k < 5; k++) begin
      in_valid[d] = 1'b1; in_data[d] = ld[k];
      tick();
    end
    in_valid[d] = 1'b0;
    tick();
    chk("exec_busy", d, busy[d], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", d, busy[d], 1'b0);
    chk("arst_valid", d, out_valid[d], 1'b0);
    chk("arst_ready", d, in_ready[d], 1'b1);
    chk("arst_mn", d, {m[d], n[d]}, 8'h00);
    chk("arst_count", d, done_count[d], 8'h00);
    chk_ops("arst", d);
    #1 rst = 1'b0;
    $display("txn dut%0d async reset during EXEC", d);
    tick();
  endtask

  initial begin
    // fields: op, a, b, c, d, res_M, res_N, hold cycles, expected M, expected N
    vecs[0] = '{4'h3, 4'h1, 4'h2, 4'h4, 4'h5, 4'hA, 4'hB, 0, 4'hA, 4'hB};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 0, 4'hA, 4'hB};
    vecs[2] = '{4'h9, 4'h6, 4'h7, 4'h8, 4'h9, 4'h7, 4'h9, 5, 4'h7, 4'h9};
    vecs[3] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'hD, 1, 4'h7, 4'h9};
    vecs[4] = '{4'hF, 4'hF, 4'hE, 4'hD, 4'hC, 4'h0, 4'hF, 2, 4'h0, 4'hF};
    vecs[5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h6, 0, 4'h5, 4'h6};

    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; in_data[d] = 4'h0; abort[d] = 1'b0;
      res_m[d] = 4'h0; res_n[d] = 4'h0; out_ready[d] = 1'b0;
    end
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      chk("rst_busy", d, busy[d], 1'b0);
      chk("rst_valid", d, out_valid[d], 1'b0);
      chk("rst_ready", d, in_ready[d], 1'b1);
      chk("rst_mn", d, {m[d], n[d]}, 8'h00);
      chk("rst_count", d, done_count[d], 8'h00);
      chk_ops("rst", d);
    end
    rst = 1'b0;
    tick();

    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 6; i++)
        run_vec(d, vecs[i], 1'b0);

    abort_seq(0);
    abort_seq(1);
    nop_burst(0);
    reset_mid_exec(1);
    run_vec(1, vecs[0], 1'b0);
    run_vec(1, vecs[1], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
